// File: rtl/mtm_alu_pkg.sv
// Shared types, opcode and error-bit constants, CRC helpers
// for the MTM ALU packet sequencer and its byte collector.
package mtm_alu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_CHECK,
    S_EXEC,
    S_WAIT_ALU,
    S_SEND
  } state_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  localparam logic [3:0] PKT_BYTES = 4'd8;

  localparam int ERR_D_HI = 6;
  localparam int ERR_C_HI = 5;
  localparam int ERR_O_HI = 4;
  localparam int ERR_D_LO = 3;
  localparam int ERR_C_LO = 2;
  localparam int ERR_O_LO = 1;

  // x^4+x+1, init 0, MSB first
  function automatic logic [3:0] crc4(
    input logic [67:0] d
  );
    logic [3:0] c;
    logic fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  // x^3+x+1, init 0, MSB first
  function automatic logic [2:0] crc3(
    input logic [36:0] d
  );
    logic [2:0] c;
    logic fb;
    c = '0;
    for (int i = 36; i >= 0; i--) begin
      fb = c[2] ^ d[i];
      c = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_ok(
    input logic [2:0] op
  );
    return (op == OP_AND) || (op == OP_OR) ||
           (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // {1,D,C,O,D,C,O,P}; P makes bits 7:0 even
  function automatic logic [7:0] err_ctl(
    input logic d,
    input logic c,
    input logic o
  );
    logic [7:0] r;
    r = '0;
    r[7] = 1'b1;
    r[ERR_D_HI] = d;
    r[ERR_C_HI] = c;
    r[ERR_O_HI] = o;
    r[ERR_D_LO] = d;
    r[ERR_C_LO] = c;
    r[ERR_O_LO] = o;
    r[0] = ^r[7:1];
    return r;
  endfunction

endpackage

// File: rtl/mtm_alu_sequencer_if.sv
// Response handshake toward the serializer.
// master: sequencer drives payload+valid; slave: serializer drives ready.
interface mtm_alu_sequencer_if;
  logic        res_vld;
  logic        res_rdy;
  logic        res_is_err;
  logic [31:0] res_c;
  logic [7:0]  res_ctl;

  modport master (
    output res_vld,
    output res_is_err,
    output res_c,
    output res_ctl,
    input  res_rdy
  );

  modport slave (
    input  res_vld,
    input  res_is_err,
    input  res_c,
    input  res_ctl,
    output res_rdy
  );
endinterface

// File: rtl/mtm_alu_byte_collector.sv
// Data byte counter, B/A operand assembly and inter-byte timeout.
// Ports: en/active/clr from FSM; a/b/count/ovf/timeout back to it.
module mtm_alu_byte_collector
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        active,
  input  logic        clr,
  input  logic [7:0]  byte_in,
  input  logic        byte_is_ctl,
  input  logic        byte_vld,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  count,
  output logic        ovf,
  output logic        timeout
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [63:0]   shreg;
  logic [TW-1:0] idle;
  logic          data_vld;

  assign data_vld = en && byte_vld && !byte_is_ctl;
  assign timeout  = active && !byte_vld && (idle == LAST);

  // first byte lands in B[31:24], eighth in A[7:0]
  assign b = shreg[63:32];
  assign a = shreg[31:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      count <= '0;
      ovf   <= 1'b0;
      idle  <= '0;
    end else if (clr || timeout) begin
      shreg <= '0;
      count <= '0;
      ovf   <= 1'b0;
      idle  <= '0;
    end else begin
      if (data_vld) begin
        if (count == PKT_BYTES) begin
          ovf <= 1'b1;
        end else begin
          shreg <= {shreg[55:0], byte_in};
          count <= count + 4'd1;
        end
      end
      if (!active || byte_vld) begin
        idle <= '0;
      end else begin
        idle <= idle + TW'(1);
      end
    end
  end

endmodule

// File: rtl/mtm_alu_sequencer.sv
// Packet sequencer: collects operand bytes, checks CTL, runs ALU,
// returns result or error. Ports: byte stream, ALU bus, res handshake.
module mtm_alu_sequencer
  import mtm_alu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_is_ctl,
  input  logic        byte_vld,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [31:0] alu_c,
  input  logic [3:0]  alu_flags,
  mtm_alu_sequencer_if.master res
);

  state_t     state;
  state_t     state_nx;
  logic [6:0] ctl_q;
  logic [3:0] count;
  logic       ovf;
  logic       timeout;
  logic       en;
  logic       active;
  logic       clr;
  logic       ctl_vld;
  logic       err_d;
  logic       err_c;
  logic       err_o;
  logic       err;

  assign en      = (state == S_IDLE) || (state == S_COLLECT);
  assign active  = (state == S_COLLECT);
  assign ctl_vld = en && byte_vld && byte_is_ctl;
  assign clr     = (state == S_SEND) && res.res_rdy;
  assign alu_op  = ctl_q[6:4];

  assign err_d = ovf || (count != PKT_BYTES);
  assign err_c = ctl_q[3:0] !=
                 crc4({alu_b, alu_a, 1'b1, ctl_q[6:4]});
  assign err_o = !op_ok(ctl_q[6:4]);
  assign err   = err_d || err_c || err_o;

  mtm_alu_byte_collector #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_col (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .active     (active),
    .clr        (clr),
    .byte_in    (byte_in),
    .byte_is_ctl(byte_is_ctl),
    .byte_vld   (byte_vld),
    .a          (alu_a),
    .b          (alu_b),
    .count      (count),
    .ovf        (ovf),
    .timeout    (timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    alu_start   = 1'b0;
    res.res_vld = 1'b0;
    unique case (state)
      S_IDLE: begin
        // a lone CTL skips COLLECT so errors keep a 2-cycle latency
        if (ctl_vld) begin
          state_nx = S_CHECK;
        end else if (byte_vld) begin
          state_nx = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (timeout) begin
          state_nx = S_IDLE;
        end else if (ctl_vld) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        state_nx = err ? S_SEND : S_EXEC;
      end
      S_EXEC: begin
        alu_start = 1'b1;
        state_nx  = S_WAIT_ALU;
      end
      S_WAIT_ALU: begin
        if (alu_done) begin
          state_nx = S_SEND;
        end
      end
      S_SEND: begin
        res.res_vld = 1'b1;
        if (res.res_rdy) begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q          <= '0;
      res.res_is_err <= 1'b0;
      res.res_c      <= '0;
      res.res_ctl    <= '0;
    end else begin
      if (ctl_vld) begin
        ctl_q <= byte_in[6:0];
      end
      if (state == S_CHECK && err) begin
        res.res_is_err <= 1'b1;
        res.res_c      <= '0;
        res.res_ctl    <= err_ctl(err_d,
                                  !err_d && err_c,
                                  !err_d && !err_c && err_o);
      end
      if (state == S_WAIT_ALU && alu_done) begin
        res.res_is_err <= 1'b0;
        res.res_c      <= alu_c;
        res.res_ctl    <= {1'b0, alu_flags,
                           crc3({alu_c, 1'b0, alu_flags})};
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_sequencer.sv
// Randomized packet bench for mtm_alu_sequencer with an
// in-bench packet/ALU model and a per-cycle output monitor.
module tb_mtm_alu_sequencer;

  localparam int TO = 24;

  typedef struct packed {
    logic        err;
    logic [31:0] c;
    logic [7:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] ccyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_is_ctl;
  logic        byte_vld;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [31:0] alu_c;
  logic [3:0]  alu_flags;

  mtm_alu_sequencer_if rif ();

  mtm_alu_sequencer #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_is_ctl(byte_is_ctl),
    .byte_vld   (byte_vld),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_c      (alu_c),
    .alu_flags  (alu_flags),
    .res        (rif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int n_starts = 0;
  int done_cyc = 0;
  logic [2:0]  last_op;
  logic [31:0] last_c;
  logic [7:0]  last_ctl;
  logic        last_err;
  exp_t q[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // CRCs by polynomial long division of msg*x^n
  function automatic logic [3:0] crc4_m(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] ^= 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] crc3_m(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (r[i]) r[i -: 4] ^= 4'b1011;
    return r[2:0];
  endfunction

  // returns {carry, overflow, zero, negative, c}
  function automatic logic [35:0] alu_m(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic [2:0] op);
    logic [32:0] s;
    logic v;
    s = '0;
    v = 1'b0;
    case (op)
      3'b000: s = {1'b0, a & b};
      3'b001: s = {1'b0, a | b};
      3'b100: begin
        s = {1'b0, a} + {1'b0, b};
        v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      3'b101: begin
        s = {1'b0, a} - {1'b0, b};
        v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      default: s = '0;
    endcase
    return {s[32], v, s[31:0] == 32'd0, s[31], s[31:0]};
  endfunction

  function automatic logic [7:0] err_code(input int k);
    logic [6:0] h;
    logic d, c, o;
    d = (k == 1);
    c = (k == 2);
    o = (k == 3);
    h = {1'b1, d, c, o, d, c, o};
    return {h, ^h};
  endfunction

  function automatic exp_t predict(input int n,
                                   input logic [31:0] b,
                                   input logic [31:0] a,
                                   input logic [7:0] ctl);
    exp_t e;
    logic [35:0] r;
    e = '0;
    e.a = a;
    e.b = b;
    e.op = ctl[6:4];
    e.err = 1'b1;
    if (n != 8)
      e.ctl = err_code(1);
    else if (ctl[3:0] != crc4_m({b, a, 1'b1, ctl[6:4]}))
      e.ctl = err_code(2);
    else if (!(ctl[6:4] inside {3'b000, 3'b001,
                                3'b100, 3'b101}))
      e.ctl = err_code(3);
    else begin
      r = alu_m(a, b, ctl[6:4]);
      e.err = 1'b0;
      e.c = r[31:0];
      e.ctl = {1'b0, r[35:32],
               crc3_m({r[31:0], 1'b0, r[35:32]})};
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int pick_gap();
    return ($urandom % 5 == 0) ? TO - 1 : $urandom_range(0, 2);
  endfunction

  task automatic send_byte(input logic [7:0] v, input logic ctl);
    byte_in = v;
    byte_is_ctl = ctl;
    byte_vld = 1'b1;
    tick();
    byte_vld = 1'b0;
    byte_is_ctl = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic reset_dut(input bit chk);
    rst = 1'b1;
    #1;
    if (chk) begin
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", 32'(alu_op), 0);
      check("rst_alu_start", 32'(alu_start), 0);
      check("rst_res_vld", 32'(rif.res_vld), 0);
      check("rst_res_is_err", 32'(rif.res_is_err), 0);
      check("rst_res_c", rif.res_c, 0);
      check("rst_res_ctl", 32'(rif.res_ctl), 0);
    end
    tick();
    rst = 1'b0;
    tick();
    q.delete();
  endtask

  task automatic send_packet(input int n,
                             input logic [63:0] d,
                             input logic [7:0] ctl,
                             input int hold);
    exp_t e;
    int vc;
    bit xfer;
    for (int i = 0; i < n; i++) begin
      send_byte((i < 8) ? d[63 - 8 * i -: 8] : 8'($urandom), 1'b0);
      repeat (pick_gap()) tick();
    end
    e = predict(n, d[63:32], d[31:0], ctl);
    e.ccyc = cyc;
    q.push_back(e);
    send_byte(ctl, 1'b1);
    vc = 0;
    xfer = 1'b0;
    for (int w = 0; w < 300 && !xfer; w++) begin
      rif.res_rdy = (vc >= hold) ? 1'($urandom) : 1'b0;
      byte_vld = ($urandom % 3 == 0);
      byte_in = 8'($urandom);
      byte_is_ctl = 1'($urandom);
      xfer = rif.res_vld && rif.res_rdy;
      if (rif.res_vld) vc++;
      tick();
    end
    byte_vld = 1'b0;
    byte_is_ctl = 1'b0;
    rif.res_rdy = 1'b0;
    if (!xfer) begin
      n_chk++;
      n_fail++;
      $display("FAIL resp_wait: no transfer within 300 cycles");
      reset_dut(0);
    end
  endtask

  task automatic abort_packet(input int k);
    for (int i = 0; i < k; i++) begin
      send_byte(8'($urandom), 1'b0);
      repeat (pick_gap()) tick();
    end
    repeat (TO) tick();
  endtask

  function automatic logic [7:0] good_ctl(input logic [63:0] d,
                                          input logic [2:0] op);
    return {1'b0, op, crc4_m({d, 1'b1, op})};
  endfunction

  // ALU stand-in with random 1..5 cycle latency
  initial begin : alu_resp
    int lat;
    alu_done = 1'b0;
    alu_c = '0;
    alu_flags = '0;
    forever begin
      tick();
      if (alu_start && !rst) begin
        lat = $urandom_range(1, 5);
        repeat (lat) tick();
        {alu_flags, alu_c} = alu_m(alu_a, alu_b, alu_op);
        alu_done = 1'b1;
        done_cyc = cyc;
        tick();
        alu_done = 1'b0;
        alu_c = $urandom;
        alu_flags = 4'($urandom);
      end
    end
  end

  initial begin : monitor
    bit started;
    bit pend;
    started = 1'b0;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        started = 1'b0;
        pend = 1'b0;
      end else begin
        if (alu_start) begin
          n_starts++;
          last_op = alu_op;
          if (q.size() == 0 || q[0].err || started) begin
            n_chk++;
            n_fail++;
            $display("FAIL alu_start: unexpected launch cyc %0d", cyc);
          end else begin
            check("start_latency", cyc - q[0].ccyc, 2);
            started = 1'b1;
          end
        end
        if (started && !rif.res_vld && q.size() > 0) begin
          check("alu_a", alu_a, q[0].a);
          check("alu_b", alu_b, q[0].b);
          check("alu_op", 32'(alu_op), 32'(q[0].op));
        end
        if (rif.res_vld) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL res_vld: asserted with nothing pending");
          end else begin
            if (!pend) begin
              if (q[0].err)
                check("err_latency", cyc - q[0].ccyc, 2);
              else begin
                check("res_launched", 32'(started), 1);
                check("res_latency", cyc - done_cyc, 1);
              end
            end
            check("res_is_err", 32'(rif.res_is_err), 32'(q[0].err));
            check("res_c", rif.res_c, q[0].c);
            check("res_ctl", 32'(rif.res_ctl), 32'(q[0].ctl));
            if (rif.res_rdy) begin
              last_c = rif.res_c;
              last_ctl = rif.res_ctl;
              last_err = rif.res_is_err;
              void'(q.pop_front());
              started = 1'b0;
              pend = 1'b0;
            end else begin
              pend = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : stim
    logic [63:0] d;
    logic [7:0]  ctl;
    logic [2:0]  op;
    logic [2:0]  ok_ops[4];
    logic [2:0]  bad_ops[4];
    int n0;
    int n;
    int kind;
    ok_ops = '{3'b000, 3'b001, 3'b100, 3'b101};
    bad_ops = '{3'b010, 3'b011, 3'b110, 3'b111};
    rst = 1'b1;
    byte_in = '0;
    byte_is_ctl = 1'b0;
    byte_vld = 1'b0;
    rif.res_rdy = 1'b0;
    tick();
    reset_dut(1);

    d = {32'h0000_0002, 32'h0000_0001};
    n0 = n_starts;
    send_packet(8, d, good_ctl(d, 3'b100), 0);
    check("add_res_c", last_c, 32'h3);
    check("add_is_err", 32'(last_err), 0);
    check("add_op", 32'(last_op), 32'(3'b100));
    check("add_starts", n_starts - n0, 1);

    n0 = n_starts;
    send_packet(7, d, good_ctl(d, 3'b100), 0);
    check("short_ctl", 32'(last_ctl), 32'hC9);
    check("short_is_err", 32'(last_err), 1);
    check("short_starts", n_starts - n0, 0);

    send_packet(8, d, good_ctl(d, 3'b100) ^ 8'h01, 1);
    check("crc_ctl", 32'(last_ctl), 32'hA5);
    send_packet(8, d, good_ctl(d, 3'b111), 2);
    check("op_ctl", 32'(last_ctl), 32'h93);
    send_packet(0, d, good_ctl(d, 3'b000), 0);
    check("lone_ctl", 32'(last_ctl), 32'hC9);
    send_packet(10, d, good_ctl(d, 3'b000), 0);
    check("long_ctl", 32'(last_ctl), 32'hC9);

    abort_packet(3);
    d = {32'hFFFF_FFFF, 32'h0000_0001};
    send_packet(8, d, good_ctl(d, 3'b101), 0);
    check("post_to_c", last_c, 32'h0000_0002);
    check("post_to_err", 32'(last_err), 0);

    d = {$urandom, $urandom};
    send_packet(8, d, good_ctl(d, 3'b001), 20);
    check("hold_c", last_c, d[63:32] | d[31:0]);

    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(1, 255)), 1'b0);
    reset_dut(1);

    for (int p = 0; p < 300; p++) begin
      kind = $urandom_range(0, 5);
      d = {$urandom, $urandom};
      op = ok_ops[$urandom % 4];
      case (kind)
        0, 1: send_packet(8, d, good_ctl(d, op), $urandom_range(0, 3));
        2: begin
          n = $urandom_range(0, 10);
          if (n == 8) n = 9;
          send_packet(n, d, 8'($urandom), $urandom_range(0, 3));
        end
        3: begin
          ctl = good_ctl(d, op) ^ {4'h0, 4'($urandom_range(1, 15))};
          send_packet(8, d, ctl, $urandom_range(0, 3));
        end
        4: begin
          op = bad_ops[$urandom % 4];
          send_packet(8, d, good_ctl(d, op), $urandom_range(0, 3));
        end
        default: abort_packet($urandom_range(1, 7));
      endcase
      repeat ($urandom_range(0, 3)) tick();
    end
    repeat (10) tick();
    check("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
